// File: rtl/cp0_pkg.sv
// Shared CP0 constants for the Count/Compare timer: register addresses,
// Status bit positions, register width and the interrupt-enable helper.
package cp0_pkg;

  localparam int CP0_REG_W = 32;

  typedef logic [CP0_REG_W-1:0] cp0_word_t;

  localparam logic [4:0] CP0_COUNT_ADDR   = 5'd9;
  localparam logic [4:0] CP0_COMPARE_ADDR = 5'd11;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM7_BIT = 15;

  // Timer interrupt is enabled when IE and IM7 are set and EXL is clear.
  function automatic logic timer_intr_en(input cp0_word_t status);
    return status[STATUS_IE_BIT] & status[STATUS_IM7_BIT] & ~status[STATUS_EXL_BIT];
  endfunction

endpackage

// File: rtl/cp0_timer_if.sv
// CP0 register access bus between the CP0 block (master) and the timer (slave).
// Protocol: no valid/ready handshake. mtc0 is a single-cycle write strobe that
// commits wdata to register Rd at the next posedge; mfc0 is a read strobe and
// rdata is valid combinationally in the same cycle (0 when mfc0 is low or Rd
// is not a timer register). count/intr are continuously valid registered levels.
interface cp0_timer_if;
  import cp0_pkg::*;

  logic      mtc0;
  logic      mfc0;
  logic [4:0] Rd;
  cp0_word_t wdata;
  cp0_word_t status;
  cp0_word_t rdata;
  cp0_word_t count;
  logic      intr;

  modport master (
    output mtc0, mfc0, Rd, wdata, status,
    input  rdata, count, intr
  );

  modport slave (
    input  mtc0, mfc0, Rd, wdata, status,
    output rdata, count, intr
  );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running 2^DIV_LOG2 prescaler. tick is high in the cycle the counter is
// all-ones; clr restarts the count from zero. DIV_LOG2 = 0 ticks every cycle.
module timer_prescaler #(
  parameter int DIV_LOG2 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  generate
    if (DIV_LOG2 == 0) begin : g_nodiv
      logic unused_ports;
      assign unused_ports = clk ^ rst ^ clr;
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_LOG2-1:0] presc_q;
      logic [DIV_LOG2-1:0] presc_d;

      // Next prescaler value: restart on clr, otherwise advance (wraps).
      always_comb begin
        presc_d = presc_q + 1'b1;
        if (clr) presc_d = '0;
      end

      // Prescaler register.
      always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
      end

      assign tick = &presc_q;
    end
  endgenerate

endmodule

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer. Count (reg 9) advances on the prescaled tick,
// Compare (reg 11) sets a sticky pending flag on equality; any Compare write
// clears it. Optional macro CP0_TIMER_INT_MASK_EN gates intr with the CP0
// Status IE/IM7/EXL bits (pending itself is never masked).
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int        DIV_LOG2    = 1,
  parameter cp0_word_t COUNT_RST   = 32'h0000_0000,
  parameter cp0_word_t COMPARE_RST = 32'hFFFF_FFFF
) (
  input logic        clk,
  input logic        rst,
  cp0_timer_if.slave bus
);

  cp0_word_t count_q, count_d;
  cp0_word_t compare_q, compare_d;
  logic      pending_q, pending_d;
  logic      tick;
  logic      count_wr;
  logic      compare_wr;

  assign count_wr   = bus.mtc0 && (bus.Rd == CP0_COUNT_ADDR);
  assign compare_wr = bus.mtc0 && (bus.Rd == CP0_COMPARE_ADDR);

  // A Count write restarts the prescaler so the new value holds a full period.
  timer_prescaler #(.DIV_LOG2(DIV_LOG2)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (count_wr),
    .tick (tick)
  );

  // Next-state for Count/Compare/pending; writes beat ticks, clear beats match.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    pending_d = pending_q;
    if (count_wr)  count_d = bus.wdata;
    else if (tick) count_d = count_q + 32'd1;
    if (compare_wr) begin
      compare_d = bus.wdata;
      pending_d = 1'b0;
    end else if (count_q == compare_q) begin
      pending_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= COUNT_RST;
      compare_q <= COMPARE_RST;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  // Read mux: registered (pre-write) values, zero when not addressed.
  always_comb begin
    bus.rdata = '0;
    if (bus.mfc0) begin
      if (bus.Rd == CP0_COUNT_ADDR)        bus.rdata = count_q;
      else if (bus.Rd == CP0_COMPARE_ADDR) bus.rdata = compare_q;
    end
  end

  assign bus.count = count_q;

`ifdef CP0_TIMER_INT_MASK_EN
  assign bus.intr = pending_q & timer_intr_en(bus.status);
`else
  logic unused_status;
  assign unused_status = ^bus.status;
  assign bus.intr = pending_q;
`endif

endmodule

// File: tb/tb_cp0_timer.sv
// Directed bench for cp0_timer with DIV_LOG2 = 1 (Count steps every 2 cycles).
module tb_cp0_timer;
  import cp0_pkg::*;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  cp0_timer_if bus ();

  cp0_timer #(
    .DIV_LOG2    (1),
    .COUNT_RST   (32'h0000_0000),
    .COMPARE_RST (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
  endtask

  task automatic idle_bus();
    bus.mtc0  = 1'b0;
    bus.mfc0  = 1'b0;
    bus.Rd    = 5'd0;
    bus.wdata = 32'h0;
  endtask

  task automatic drive_write(input logic [4:0] rd, input logic [31:0] wd);
    bus.mtc0  = 1'b1;
    bus.Rd    = rd;
    bus.wdata = wd;
    wait_edges(1);
    idle_bus();
  endtask

  // Test 1: reset values, counting at half rate, Compare reset value.
  task automatic test_reset();
    do_reset();
    if (bus.count !== 32'h0) begin nerr++; $display("FAIL reset_count got %h exp %h", bus.count, 32'h0); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL reset_intr got %b exp 0", bus.intr); end
    nvec++;
    if (bus.rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata_idle got %h exp 0", bus.rdata); end
    nvec++;
    wait_edges(10);
    if (bus.count !== 32'd5) begin nerr++; $display("FAIL run10_count got %h exp %h", bus.count, 32'd5); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL run10_intr got %b exp 0", bus.intr); end
    nvec++;
    bus.mfc0 = 1'b1; bus.Rd = 5'd11; #1;
    if (bus.rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL reset_compare_rd got %h exp FFFFFFFF", bus.rdata); end
    nvec++;
    idle_bus();
  endtask

  // Tests 2 and 3: match raises sticky intr, Compare write clears it.
  task automatic test_match_and_clear();
    do_reset();
    drive_write(5'd11, 32'd8);           // edge 1
    wait_edges(15);                      // edge 16: count becomes 8
    if (bus.count !== 32'd8) begin nerr++; $display("FAIL match_count got %h exp 8", bus.count); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL match_latency_intr got %b exp 0", bus.intr); end
    nvec++;
    wait_edges(1);                       // edge 17
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL match_intr got %b exp 1", bus.intr); end
    nvec++;
    wait_edges(4);                       // edge 21: count 10
    if (bus.count !== 32'd10) begin nerr++; $display("FAIL sticky_count got %h exp 10", bus.count); end
    nvec++;
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL sticky_intr got %b exp 1", bus.intr); end
    nvec++;
    bus.mtc0 = 1'b1; bus.mfc0 = 1'b1; bus.Rd = 5'd11; bus.wdata = 32'd100; #1;
    if (bus.rdata !== 32'd8) begin nerr++; $display("FAIL rd_during_wr got %h exp 8", bus.rdata); end
    nvec++;
    wait_edges(1);
    idle_bus();
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL clear_intr got %b exp 0", bus.intr); end
    nvec++;
    bus.mfc0 = 1'b1; bus.Rd = 5'd11; #1;
    if (bus.rdata !== 32'd100) begin nerr++; $display("FAIL compare_rd got %h exp 100", bus.rdata); end
    nvec++;
    idle_bus();
    wait_edges(1);
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL clear_hold_intr got %b exp 0", bus.intr); end
    nvec++;
  endtask

  // Test 4: Count wraps FFFFFFFF -> 0 silently and then matches Compare = 1.
  task automatic test_wrap();
    do_reset();
    drive_write(5'd9, 32'hFFFF_FFFE);    // edge 1
    bus.mfc0 = 1'b1; bus.Rd = 5'd9; #1;
    if (bus.rdata !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL count_rd got %h exp FFFFFFFE", bus.rdata); end
    nvec++;
    idle_bus();
    drive_write(5'd11, 32'd1);           // edge 1 after count write
    wait_edges(1);
    if (bus.count !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wrap_ff got %h exp FFFFFFFF", bus.count); end
    nvec++;
    wait_edges(2);
    if (bus.count !== 32'h0) begin nerr++; $display("FAIL wrap_zero got %h exp 0", bus.count); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL wrap_noflag got %b exp 0", bus.intr); end
    nvec++;
    wait_edges(2);
    if (bus.count !== 32'd1) begin nerr++; $display("FAIL wrap_one got %h exp 1", bus.count); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL wrap_pre_intr got %b exp 0", bus.intr); end
    nvec++;
    wait_edges(1);
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL wrap_intr got %b exp 1", bus.intr); end
    nvec++;
  endtask

  // Test 5: Compare write on a match edge wins; Count write keeps pending; mask.
  task automatic test_clear_priority();
    do_reset();
    drive_write(5'd11, 32'h20);
    drive_write(5'd9, 32'h20);
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL prio_setup_intr got %b exp 0", bus.intr); end
    nvec++;
    drive_write(5'd11, 32'h20);          // match present, clear wins
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL prio_clear_wins got %b exp 0", bus.intr); end
    nvec++;
    wait_edges(1);
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL prio_reset_next got %b exp 1", bus.intr); end
    nvec++;
    drive_write(5'd9, 32'h5);
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL count_wr_keeps got %b exp 1", bus.intr); end
    nvec++;
    if (bus.count !== 32'h5) begin nerr++; $display("FAIL count_wr_val got %h exp 5", bus.count); end
    nvec++;
`ifdef CP0_TIMER_INT_MASK_EN
    bus.status = 32'h0; #1;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL mask_off got %b exp 0", bus.intr); end
    nvec++;
    bus.status = 32'h0000_8003; #1;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL mask_exl got %b exp 0", bus.intr); end
    nvec++;
    bus.status = 32'h0000_8001; #1;
    if (bus.intr !== 1'b1) begin nerr++; $display("FAIL mask_on got %b exp 1", bus.intr); end
    nvec++;
`endif
  endtask

  // Accesses to other CP0 addresses leave the timer alone and read as zero.
  task automatic test_other_rd();
    do_reset();
    bus.mtc0 = 1'b1; bus.mfc0 = 1'b1; bus.Rd = 5'd10; bus.wdata = 32'h1234; #1;
    if (bus.rdata !== 32'h0) begin nerr++; $display("FAIL other_rd got %h exp 0", bus.rdata); end
    nvec++;
    wait_edges(1);
    idle_bus();
    if (bus.count !== 32'h0) begin nerr++; $display("FAIL other_wr_count got %h exp 0", bus.count); end
    nvec++;
    bus.mfc0 = 1'b1; bus.Rd = 5'd11; #1;
    if (bus.rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL other_wr_compare got %h exp FFFFFFFF", bus.rdata); end
    nvec++;
    idle_bus();
  endtask

  // Test 6: reset in the middle of operation with intr high.
  task automatic test_mid_reset();
    do_reset();
    drive_write(5'd11, 32'h55);
    drive_write(5'd9, 32'h55);
    wait_edges(1);
    if (bus.count !== 32'h55 || bus.intr !== 1'b1) begin
      nerr++; $display("FAIL midrst_setup count %h intr %b exp 55 1", bus.count, bus.intr);
    end
    nvec++;
    do_reset();
    if (bus.count !== 32'h0) begin nerr++; $display("FAIL midrst_count got %h exp 0", bus.count); end
    nvec++;
    if (bus.intr !== 1'b0) begin nerr++; $display("FAIL midrst_intr got %b exp 0", bus.intr); end
    nvec++;
    bus.mfc0 = 1'b1; bus.Rd = 5'd11; #1;
    if (bus.rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL midrst_compare got %h exp FFFFFFFF", bus.rdata); end
    nvec++;
    idle_bus();
    wait_edges(1);
    if (bus.count !== 32'h0) begin nerr++; $display("FAIL midrst_presc1 got %h exp 0", bus.count); end
    nvec++;
    wait_edges(1);
    if (bus.count !== 32'h1) begin nerr++; $display("FAIL midrst_presc2 got %h exp 1", bus.count); end
    nvec++;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    idle_bus();
`ifdef CP0_TIMER_INT_MASK_EN
    bus.status = 32'h0000_8001;
`else
    bus.status = 32'h0;
`endif
    test_reset();
    test_match_and_clear();
    test_wrap();
    test_clear_priority();
`ifdef CP0_TIMER_INT_MASK_EN
    bus.status = 32'h0000_8001;
`endif
    test_other_rd();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
